// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with a miss FSM that
// waits out a fixed memory latency, plus full invalidate and hit/miss counters.
module icache_dm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSETS   = 64,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              icache_stall,
  input  logic              invalidate,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [NSETS-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] data_q [NSETS];
  logic [TAG_W-1:0]  tag_q [NSETS];
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic              fill_valid_q, fill_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] last_inst_q, last_inst_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              unused_addr_bits;

  assign req_idx          = cpu_addr[IDX_W+1:2];
  assign req_tag          = cpu_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // A same-cycle invalidate forces a miss so no stale line can be returned.
  assign hit = cpu_req && (state_q == S_IDLE) && !invalidate &&
               valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign icache_stall = cpu_req && !hit;
  assign cpu_inst     = hit ? data_q[req_idx] : last_inst_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    fill_valid_d = fill_valid_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    last_inst_d  = last_inst_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (hit) begin
      last_inst_d = data_q[req_idx];
      if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_req && !hit) begin
          mem_req_d    = 1'b1;
          mem_addr_d   = {cpu_addr[ADDR_W-1:2], 2'b00};
          miss_idx_d   = req_idx;
          miss_tag_d   = req_tag;
          fill_valid_d = 1'b1;
          cnt_d        = LAT_W'(MEM_LAT);
          state_d      = S_WAIT;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) state_d = S_FILL;
        if (invalidate) fill_valid_d = 1'b0;
      end
      S_FILL: begin
        state_d = S_IDLE;
        valid_d[miss_idx_q] = fill_valid_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Invalidate overrides any fill landing in the same cycle.
    if (invalidate) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      valid_q      <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      fill_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      last_inst_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
      fill_valid_q <= fill_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      last_inst_q  <= last_inst_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL) begin
      data_q[miss_idx_q] <= mem_data;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule
